// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: op encodings, FSM states and
// result-selection helpers used by both the sequencer and its special-case unit.
package div_sequencer_pkg;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  localparam logic [1:0] DIV_SIGNED_ON  = 2'b11;
  localparam logic [1:0] DIV_SIGNED_OFF = 2'b00;

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH, DONE} state_t;

  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // The divider zero-extends W results, so word results are re-extended here.
  function automatic logic [63:0] pick_result(input logic [1:0] op, input logic word,
                                              input logic [63:0] q, input logic [63:0] r);
    logic [63:0] v;
    v = op_rem(op) ? r : q;
    return word ? sext32(v[31:0]) : v;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EXU-side request/response handshake of the divide sequencer.
interface div_sequencer_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic            in_word;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;

  modport master (
    output in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/div_special_result.sv
// Combinational divide-by-zero and signed-overflow detection with the
// architecturally defined results for those cases.
module div_special_result
  import div_sequencer_pkg::*;
(
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        word,
  input  logic        is_signed,
  output logic        is_zero,
  output logic        is_ovf,
  output logic [63:0] special_q,
  output logic [63:0] special_r
);

  logic [63:0] dividend;

  always_comb begin
    is_zero  = word ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
    is_ovf   = is_signed &&
               (word ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                     : ((src1 == 64'h8000_0000_0000_0000) && (src2 == {64{1'b1}})));
    dividend = word ? sext32(src1[31:0]) : src1;
    special_q = {64{1'b1}};
    special_r = dividend;
    if (!is_zero && is_ovf) begin
      special_q = dividend;
      special_r = 64'd0;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Front end for the iterative 64-bit divider: resolves special cases locally,
// reuses the last divider result for matching operands, else runs the divider.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  div_sequencer_if.slave  exu,
  output logic            div_valid,
  output logic            div_flush,
  output logic            div_w,
  output logic [1:0]      div_signed,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  state_t          state_reg;
  logic [1:0]      op_reg;
  logic            word_reg;
  logic [XLEN-1:0] src1_reg;
  logic [XLEN-1:0] src2_reg;
  logic [XLEN-1:0] out_data_reg;
  logic            out_valid_reg;
  logic            div_valid_reg;
  logic            div_flush_reg;

  logic            accept;
  logic            req_signed;
  logic            is_zero;
  logic            is_ovf;
  logic [XLEN-1:0] special_q;
  logic [XLEN-1:0] special_r;
  logic [XLEN-1:0] special_data;
  logic            cache_hit;
  logic [XLEN-1:0] cache_data;
  logic            result_commit;

  assign exu.in_ready  = (state_reg == IDLE) && div_ready;
  assign exu.out_valid = out_valid_reg;
  assign exu.out_data  = out_data_reg;

  assign accept        = exu.in_valid && exu.in_ready && !exu.flush;
  assign req_signed    = op_signed(exu.in_op);
  assign special_data  = op_rem(exu.in_op) ? special_r : special_q;
  assign result_commit = (state_reg == WAIT) && !exu.flush && div_out_valid;

  assign div_valid    = div_valid_reg;
  assign div_flush    = div_flush_reg;
  assign div_w        = word_reg;
  assign div_signed   = op_signed(op_reg) ? DIV_SIGNED_ON : DIV_SIGNED_OFF;
  assign div_dividend = src1_reg;
  assign div_divisor  = src2_reg;

  div_special_result u_special (
    .src1      (exu.in_src1),
    .src2      (exu.in_src2),
    .word      (exu.in_word),
    .is_signed (req_signed),
    .is_zero   (is_zero),
    .is_ovf    (is_ovf),
    .special_q (special_q),
    .special_r (special_r)
  );

  generate
    if (CACHE_EN) begin : g_cache
      logic            valid_reg;
      logic            word_c_reg;
      logic            signed_c_reg;
      logic [XLEN-1:0] src1_c_reg;
      logic [XLEN-1:0] src2_c_reg;
      logic [XLEN-1:0] q_c_reg;
      logic [XLEN-1:0] r_c_reg;

      // Flushed results never land here, so the entry survives a flush intact.
      always_ff @(posedge clock) begin
        if (!reset) begin
          valid_reg    <= 1'b0;
          word_c_reg   <= 1'b0;
          signed_c_reg <= 1'b0;
          src1_c_reg   <= '0;
          src2_c_reg   <= '0;
          q_c_reg      <= '0;
          r_c_reg      <= '0;
        end else if (result_commit) begin
          valid_reg    <= 1'b1;
          word_c_reg   <= word_reg;
          signed_c_reg <= op_signed(op_reg);
          src1_c_reg   <= src1_reg;
          src2_c_reg   <= src2_reg;
          q_c_reg      <= div_quotient;
          r_c_reg      <= div_remainder;
        end
      end

      assign cache_hit  = valid_reg && (src1_c_reg == exu.in_src1) && (src2_c_reg == exu.in_src2) &&
                          (word_c_reg == exu.in_word) && (signed_c_reg == req_signed);
      assign cache_data = pick_result(exu.in_op, exu.in_word, q_c_reg, r_c_reg);
    end else begin : g_no_cache
      assign cache_hit  = 1'b0;
      assign cache_data = '0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_DIV;
      word_reg      <= 1'b0;
      src1_reg      <= '0;
      src2_reg      <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      div_valid_reg <= 1'b0;
      div_flush_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg   <= exu.in_op;
            word_reg <= exu.in_word;
            src1_reg <= exu.in_src1;
            src2_reg <= exu.in_src2;
            if (is_zero || is_ovf) begin
              out_data_reg  <= special_data;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (cache_hit) begin
              out_data_reg  <= cache_data;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              div_valid_reg <= 1'b1;
              state_reg     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (exu.flush) begin
            div_flush_reg <= 1'b1;
            state_reg     <= FLUSH;
          end else if (div_out_valid) begin
            out_data_reg  <= pick_result(op_reg, word_reg, div_quotient, div_remainder);
            out_valid_reg <= 1'b1;
            div_valid_reg <= 1'b0;
            state_reg     <= DONE;
          end
        end
        FLUSH: begin
          // A late result strobe is ignored; only divider idle ends the flush.
          if (div_ready) begin
            div_valid_reg <= 1'b0;
            div_flush_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        DONE: begin
          if (exu.flush || exu.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
